// File: rtl/mem_pkg.sv
// Shared size encodings, FSM state type and byte-lane mask helper for the MEM-stage access unit.
// Lanes are little-endian: lane k holds bits [8k+7:8k] of the memory word.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        MAU_IDLE      = 1'b0,
        MAU_RMW_WRITE = 1'b1
    } mau_state_t;

    // A half access only looks at lo[1], so an odd half address falls onto the enclosing half.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << lo;
            SIZE_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/half/word out of a memory word and sign- or zero-extends it.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
        byte_sign = byte_sel[7] & ~load_unsigned;
        half_sign = half_sel[15] & ~load_unsigned;

        load_data = word;
        case (size)
            SIZE_BYTE: load_data = {{24{byte_sign}}, byte_sel};
            SIZE_HALF: load_data = {{16{half_sign}}, half_sel};
            default:   load_data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage front end to a word-wide data memory; sub-word stores run a 2-cycle read-modify-write.
// Define MAU_ALIGN_CHECK_EN to flag misaligned half/word accesses on addr_err instead of ignoring low bits.
//
//  state          | meaning
//  ---------------+-----------------------------------------------------------
//  MAU_IDLE       | accept loads/stores; sub-word store reads the word, stalls
//  MAU_RMW_WRITE  | write the merged word held in merge_reg, requests ignored
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              addr_err,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_write_data,
    output logic              dm_mem_write,
    output logic              dm_mem_read,
    input  logic [DATA_W-1:0] dm_read_data
);

    mau_state_t        state;
    logic [DATA_W-1:0] merge_reg;

    logic              is_word;
    logic              is_half;
    logic              misaligned;
    logic              start_rmw;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        mask;
    logic [DATA_W-1:0] store_lanes;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] extracted;

    load_extract u_load_extract (
        .word          (dm_read_data),
        .addr_lo       (addr[1:0]),
        .size          (mem_size),
        .load_unsigned (load_unsigned),
        .load_data     (extracted)
    );

    always_comb begin
        is_word   = (mem_size == SIZE_WORD) || (mem_size == 2'b11);
        is_half   = (mem_size == SIZE_HALF);
        word_addr = {addr[ADDR_W-1:2], 2'b00};
`ifdef MAU_ALIGN_CHECK_EN
        misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        start_rmw = mem_write & ~is_word & ~misaligned;
    end

    // Replicate the store value across lanes so the mask alone picks what lands where.
    always_comb begin
        mask        = lane_mask(mem_size, addr[1:0]);
        store_lanes = (mem_size == SIZE_BYTE) ? {4{store_data[7:0]}} : {2{store_data[15:0]}};
        merged      = dm_read_data;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                merged[8*k +: 8] = store_lanes[8*k +: 8];
            end
        end
    end

    always_comb begin
        load_data     = '0;
        stall         = 1'b0;
        addr_err      = 1'b0;
        dm_address    = '0;
        dm_write_data = '0;
        dm_mem_write  = 1'b0;
        dm_mem_read   = 1'b0;
        if (rst) begin
            // everything stays quiet, including a pending RMW write
        end else if (state == MAU_RMW_WRITE) begin
            dm_mem_write  = 1'b1;
            dm_write_data = merge_reg;
            dm_address    = word_addr;
        end else if ((mem_read | mem_write) & misaligned) begin
            addr_err = 1'b1;
        end else if (mem_write) begin
            dm_address = word_addr;
            if (start_rmw) begin
                dm_mem_read = 1'b1;
                stall       = 1'b1;
            end else begin
                dm_mem_write  = 1'b1;
                dm_write_data = store_data;
            end
        end else if (mem_read) begin
            dm_mem_read = 1'b1;
            dm_address  = word_addr;
            load_data   = extracted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MAU_IDLE;
            merge_reg <= '0;
        end else begin
            case (state)
                MAU_IDLE: begin
                    if (start_rmw) begin
                        merge_reg <= merged;
                        state     <= MAU_RMW_WRITE;
                    end
                end
                MAU_RMW_WRITE: state <= MAU_IDLE;
                default:       state <= MAU_IDLE;
            endcase
        end
    end

endmodule
